// File: rtl/cpu_debug_slave_scan_master.sv
// On-chip virtual-JTAG scan initiator for the CPU debug slave: one command becomes an
// optional virtual IR update followed by a full DR scan, returning the captured DR.
module cpu_debug_slave_scan_master #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                abort,
  output logic                rsp_valid,
  output logic                rsp_aborted,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti
);

  localparam int unsigned HC_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int unsigned BC_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_t;

  state_t              state;
  logic [HC_W-1:0]     hc;
  logic [BC_W-1:0]     bc;
  logic [DR_WIDTH-1:0] sr;
  logic                tdo_q;
  logic                ir_valid;
  logic                aborted;
  logic                tck_rise_c;
  logic                period_end_c;

  // vj_tck doubles as the half-period phase bit
  assign tck_rise_c   = (hc == HC_LAST) && !vj_tck;
  assign period_end_c = (hc == HC_LAST) && vj_tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hc          <= '0;
      bc          <= '0;
      sr          <= '0;
      tdo_q       <= 1'b0;
      ir_valid    <= 1'b0;
      aborted     <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_aborted <= 1'b0;
      rsp_dr      <= '0;
      vj_tck      <= 1'b0;
      vj_tdi      <= 1'b0;
      vj_ir_in    <= '0;
      vj_uir      <= 1'b0;
      vj_cdr      <= 1'b0;
      vj_sdr      <= 1'b0;
      vj_udr      <= 1'b0;
      vj_rti      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // abort is deliberately ignored here; a simultaneous command is still accepted
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            sr        <= cmd_dr;
            bc        <= '0;
            hc        <= '0;
            vj_tck    <= 1'b0;
            aborted   <= 1'b0;
            if (ir_valid && (cmd_ir == vj_ir_in)) begin
              state  <= CDR;
              vj_cdr <= 1'b1;
            end else begin
              state    <= UIR;
              vj_uir   <= 1'b1;
              vj_ir_in <= cmd_ir;
            end
          end
        end
        DONE: begin
          rsp_valid   <= 1'b1;
          rsp_aborted <= aborted;
          rsp_dr      <= sr;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          if (abort) begin
            // sr keeps the partially shifted data so it can be returned
            state   <= DONE;
            aborted <= 1'b1;
            hc      <= '0;
            vj_tck  <= 1'b0;
            vj_tdi  <= 1'b0;
            vj_uir  <= 1'b0;
            vj_cdr  <= 1'b0;
            vj_sdr  <= 1'b0;
            vj_udr  <= 1'b0;
            vj_rti  <= 1'b0;
            if (state == UIR) ir_valid <= 1'b0;
          end else begin
            if (hc == HC_LAST) begin
              hc     <= '0;
              vj_tck <= ~vj_tck;
            end else begin
              hc <= hc + HC_W'(1);
            end
            if (tck_rise_c) tdo_q <= vj_tdo;
            if (period_end_c) begin
              case (state)
                UIR: begin
                  ir_valid <= 1'b1;
                  vj_uir   <= 1'b0;
                  vj_cdr   <= 1'b1;
                  state    <= CDR;
                end
                CDR: begin
                  vj_cdr <= 1'b0;
                  vj_sdr <= 1'b1;
                  vj_tdi <= sr[0];
                  state  <= SDR;
                end
                SDR: begin
                  sr <= {tdo_q, sr[DR_WIDTH-1:1]};
                  bc <= bc + BC_W'(1);
                  if (bc == BC_LAST) begin
                    vj_sdr <= 1'b0;
                    vj_udr <= 1'b1;
                    vj_tdi <= 1'b0;
                    state  <= UDR;
                  end else begin
                    vj_tdi <= sr[1];
                  end
                end
                UDR: begin
                  vj_udr <= 1'b0;
                  vj_rti <= 1'b1;
                  state  <= RTI;
                end
                RTI: begin
                  vj_rti <= 1'b0;
                  state  <= DONE;
                end
                default: state <= DONE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_slave_scan_master.sv
// Randomized scoreboard bench for cpu_debug_slave_scan_master with a loopback / pattern
// virtual-JTAG slave, plus a small directed run of a TCK_DIV=1 instance.
module tb_cpu_debug_slave_scan_master;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int TD  = 4;
  localparam int P   = 2 * TD;

  typedef struct {
    logic [DR-1:0]  dr;
    logic           ab;
    int             lat;
    int             uir;
    int             sdr;
    logic [IRW-1:0] ir;
    int             acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic reset_n;
  logic cmd_valid, cmd_ready, abort;
  logic [IRW-1:0] cmd_ir, vj_ir_in;
  logic [DR-1:0] cmd_dr, rsp_dr;
  logic rsp_valid, rsp_aborted;
  logic vj_tck, vj_tdi, vj_tdo, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;

  logic c1_valid, c1_ready, c1_abort;
  logic [IRW-1:0] c1_ir, vj1_ir_in;
  logic [DR-1:0] c1_dr, r1_dr;
  logic r1_valid, r1_aborted;
  logic vj1_tck, vj1_tdi, vj1_tdo, vj1_uir, vj1_cdr, vj1_sdr, vj1_udr, vj1_rti;

  always #5 clk = ~clk;

  cpu_debug_slave_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DR), .TCK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .abort(abort), .rsp_valid(rsp_valid),
    .rsp_aborted(rsp_aborted), .rsp_dr(rsp_dr), .vj_tck(vj_tck), .vj_tdi(vj_tdi),
    .vj_tdo(vj_tdo), .vj_ir_in(vj_ir_in), .vj_uir(vj_uir), .vj_cdr(vj_cdr),
    .vj_sdr(vj_sdr), .vj_udr(vj_udr), .vj_rti(vj_rti));

  cpu_debug_slave_scan_master #(.IR_WIDTH(IRW), .DR_WIDTH(DR), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_ir(c1_ir), .cmd_dr(c1_dr), .abort(c1_abort), .rsp_valid(r1_valid),
    .rsp_aborted(r1_aborted), .rsp_dr(r1_dr), .vj_tck(vj1_tck), .vj_tdi(vj1_tdi),
    .vj_tdo(vj1_tdo), .vj_ir_in(vj1_ir_in), .vj_uir(vj1_uir), .vj_cdr(vj1_cdr),
    .vj_sdr(vj1_sdr), .vj_udr(vj1_udr), .vj_rti(vj1_rti));

  // Slave models: loopback delays tdi by one tck; pattern mode plays pat[k] in DR period k
  int            cyc = 0;
  int            sdr_rises = 0;
  int            base = 0;
  int            idx;
  bit            mode = 1'b0;
  logic [DR-1:0] pat = '0;
  logic          lb = 1'b0;
  logic          lb1 = 1'b0;
  logic          tdo_pat;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge vj_tck) lb <= vj_tdi;
  always @(posedge vj_tck) if (vj_sdr) sdr_rises <= sdr_rises + 1;
  always @(posedge vj1_tck) lb1 <= vj1_tdi;
  always_comb begin
    idx     = sdr_rises - base;
    tdo_pat = (idx >= 0 && idx < DR) ? pat[idx] : 1'b0;
  end
  assign vj_tdo  = mode ? tdo_pat : lb;
  assign vj1_tdo = lb1;

  exp_t sb[$];
  chk_t chk_q[$];
  bit   drv_done = 1'b0;
  bit   wd = 1'b0;

  logic [IRW-1:0] m_ir = '0;
  bit             m_irv = 1'b0;

  task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  function automatic int win(input int s, input int len, input int t);
    int hi;
    hi = ((s + len) * P < t) ? (s + len) * P : t;
    return (hi > s * P) ? hi - s * P : 0;
  endfunction

  task automatic do_cmd(input logic [IRW-1:0] ir, input logic [DR-1:0] dr, input bit pmode,
                        input logic [DR-1:0] ptn, input bit ab_en, input int m, input int j);
    exp_t e;
    bit skip;
    int pre, periods, t, n, k;
    logic [DR-1:0] cap;
    @(negedge clk);
    k = 0;
    while (cmd_ready !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) begin post("ready_timeout", 64'(cmd_ready), 64'd1); return; end
    mode = pmode; pat = ptn; base = sdr_rises;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr; abort = 1'($urandom_range(0, 1));
    skip    = m_irv && (ir == m_ir);
    pre     = skip ? 1 : 2;
    periods = pre + DR + 2;
    t       = ab_en ? m * P + j : periods * P;
    n       = (ab_en ? m : periods) - pre;
    if (n < 0) n = 0;
    if (n > DR) n = DR;
    for (int b = 0; b < DR; b++) cap[b] = pmode ? ptn[b] : ((b == 0) ? 1'b0 : dr[b-1]);
    e.dr  = (cap << (DR - n)) | (dr >> n);
    e.ab  = ab_en;
    e.lat = t + 1;
    e.uir = skip ? 0 : win(0, 1, t);
    e.sdr = win(pre, DR, t);
    if (!skip) begin m_ir = ir; m_irv = !(ab_en && m == 0); end
    e.ir  = m_ir;
    @(posedge clk);
    @(negedge clk);
    e.acc = cyc;
    sb.push_back(e);
    k = 0;
    while (cmd_ready !== 1'b1 && k < 2000) begin
      abort     = (ab_en && cyc == e.acc + t - 1);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_ir    = IRW'($urandom);
      cmd_dr    = DR'({$urandom, $urandom});
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (k >= 2000) post("busy_timeout", 64'(cmd_ready), 64'd1);
  endtask

  // Driver
  initial begin
    logic [DR-1:0] d, p;
    int k, pre;
    bit ab;
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_ir = '0; cmd_dr = '0;
    c1_valid = 1'b0; c1_abort = 1'b0; c1_ir = '0; c1_dr = '0;
    repeat (2) @(negedge clk);
    post("rst_ready", 64'(cmd_ready), 64'd1);
    post("rst_rsp", 64'({rsp_valid, rsp_aborted, rsp_dr}), 64'd0);
    post("rst_vj", 64'({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_ir_in}), 64'd0);
    reset_n = 1'b1;

    d = 38'h2A_5A5A_5A5A;
    do_cmd(2'b01, d, 1'b0, '0, 1'b0, 0, 0);
    do_cmd(2'b01, d, 1'b0, '0, 1'b0, 0, 0);
    do_cmd(2'b10, DR'({$urandom, $urandom}), 1'b0, '0, 1'b0, 0, 0);
    do_cmd(2'b10, '0, 1'b1, {DR{1'b1}}, 1'b0, 0, 0);
    do_cmd(2'b11, d, 1'b0, '0, 1'b1, 2 + 10, 3);

    for (int i = 0; i < 24; i++) begin
      logic [IRW-1:0] ir;
      ir = ($urandom_range(0, 1) == 1) ? m_ir : IRW'($urandom);
      d  = DR'({$urandom, $urandom});
      p  = ($urandom_range(0, 3) == 0) ? {DR{1'b1}} : DR'({$urandom, $urandom});
      ab = ($urandom_range(0, 2) == 0);
      pre = (m_irv && ir == m_ir) ? 1 : 2;
      do_cmd(ir, d, 1'($urandom_range(0, 1)), p, ab,
             $urandom_range(0, pre + DR + 1), $urandom_range(1, P - 1));
    end

    // Reset pulse in the middle of a scan
    @(negedge clk);
    cmd_ir = ~m_ir; cmd_dr = DR'({$urandom, $urandom}); cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (vj_cdr !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    post("cdr_reached", 64'(vj_cdr), 64'd1);
    reset_n = 1'b0;
    #1;
    post("midrst_vj", 64'({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_ir_in}), 64'd0);
    post("midrst_ready", 64'(cmd_ready), 64'd1);
    post("midrst_rsp", 64'({rsp_valid, rsp_dr}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_irv = 1'b0; m_ir = '0;
    do_cmd(2'b00, DR'({$urandom, $urandom}), 1'b0, '0, 1'b0, 0, 0);
    do_cmd(2'b00, DR'({$urandom, $urandom}), 1'b1, DR'({$urandom, $urandom}), 1'b0, 0, 0);

    // TCK_DIV=1 instance, loopback slave
    @(negedge clk);
    d = DR'({$urandom, $urandom});
    c1_valid = 1'b1; c1_ir = 2'b01; c1_dr = d;
    @(posedge clk);
    @(negedge clk);
    c1_valid = 1'b0;
    k = cyc;
    while (r1_valid !== 1'b1 && cyc - k < 300) @(negedge clk);
    post("div1_latency", 64'(cyc - k), 64'd85);
    post("div1_dr", 64'(r1_dr), 64'({d[DR-2:0], 1'b0}));
    post("div1_aborted", 64'(r1_aborted), 64'd0);
    post("div1_ready", 64'(c1_ready), 64'd1);
    post("div1_vj", 64'({vj1_tck, vj1_tdi, vj1_uir, vj1_cdr, vj1_sdr, vj1_udr, vj1_rti, vj1_ir_in}),
         64'd1);
    repeat (4) @(negedge clk);
    drv_done = 1'b1;
  end

  initial begin
    #500000;
    wd = 1'b1;
  end

  // Monitor / scoreboard
  int   errors = 0;
  int   checks = 0;
  int   uir_cnt = 0;
  int   sdr_cnt = 0;
  logic prev_tdi = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    chk_t c;
    while (!(drv_done || wd)) begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        cmp(c.name, c.act, c.exp);
      end
      if (!reset_n) begin
        uir_cnt = 0;
        sdr_cnt = 0;
      end else begin
        if (vj_uir) uir_cnt++;
        if (vj_sdr) sdr_cnt++;
        cmp("strobe_onehot", 64'($countones({vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}) > 1), 64'd0);
        cmp("tdi_change_tck_low", 64'((vj_tdi !== prev_tdi) && vj_tck), 64'd0);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            cmp("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            cmp("rsp_dr", 64'(rsp_dr), 64'(e.dr));
            cmp("rsp_aborted", 64'(rsp_aborted), 64'(e.ab));
            cmp("latency", 64'(cyc - e.acc), 64'(e.lat));
            cmp("uir_cycles", 64'(uir_cnt), 64'(e.uir));
            cmp("sdr_cycles", 64'(sdr_cnt), 64'(e.sdr));
            cmp("vj_ir_in", 64'(vj_ir_in), 64'(e.ir));
            cmp("ready_at_rsp", 64'(cmd_ready), 64'd1);
          end
          uir_cnt = 0;
          sdr_cnt = 0;
        end
      end
      prev_tdi = vj_tdi;
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    cmp("sb_drained", 64'(sb.size()), 64'd0);
    cmp("watchdog", 64'(wd), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
